// File: rtl/bus_master_arb.sv
// rtl/bus_master_arb.sv - round-robin four-master shared-bus arbiter with registered one-hot grant and combinational datapath mux
//
// Ports:
//   clk            system clock, rising edge
//   reset_         asynchronous active-low reset
//   mN_req_        master N bus request, active-low (N = 0..3)
//   mN_addr        master N address
//   mN_as_         master N address strobe, active-low
//   mN_rw          master N direction, 1 = read, 0 = write
//   mN_wr_data     master N write data
//   mN_grnt_       master N grant, active-low, registered one-hot
//   s_addr         shared address; s_addr[9:8] feeds the chip-select decoder
//   s_as_          shared address strobe, active-low
//   s_rw           shared direction
//   s_wr_data      shared write data
//   bus_idle       registered, high when no master owns the bus

`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 10
`endif

module bus_master_arb #(
    parameter int ADDR_W   = `BUS_ADDR_WIDTH,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              m0_req_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_as_,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m1_req_,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_as_,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m2_req_,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic              m2_as_,
    input  logic              m2_rw,
    input  logic [DATA_W-1:0] m2_wr_data,
    input  logic              m3_req_,
    input  logic [ADDR_W-1:0] m3_addr,
    input  logic              m3_as_,
    input  logic              m3_rw,
    input  logic [DATA_W-1:0] m3_wr_data,
    output logic              m0_grnt_,
    output logic              m1_grnt_,
    output logic              m2_grnt_,
    output logic              m3_grnt_,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_as_,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_wr_data,
    output logic              bus_idle
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Hold counter only needs to reach MAX_HOLD; it saturates at all-ones.
    localparam int                HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    state_t            r_st;
    logic [1:0]        r_owner;
    logic [1:0]        r_last;
    logic [HOLD_W-1:0] r_hold;
    logic [3:0]        r_grnt_n;
    logic              r_bus_idle;

    state_t            w_st_nxt;
    logic [1:0]        w_owner_nxt;
    logic [1:0]        w_last_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic [3:0]        w_req;
    logic [3:0]        w_as_n;
    logic [ADDR_W-1:0] w_addr [4];
    logic [DATA_W-1:0] w_data [4];
    logic [3:0]        w_rw;
    logic [2:0]        w_idle_pick;
    logic [2:0]        w_next_pick;
    logic              w_preempt;

    assign w_req  = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign w_as_n = {m3_as_, m2_as_, m1_as_, m0_as_};
    assign w_rw   = {m3_rw, m2_rw, m1_rw, m0_rw};
    assign w_addr[0] = m0_addr;
    assign w_addr[1] = m1_addr;
    assign w_addr[2] = m2_addr;
    assign w_addr[3] = m3_addr;
    assign w_data[0] = m0_wr_data;
    assign w_data[1] = m1_wr_data;
    assign w_data[2] = m2_wr_data;
    assign w_data[3] = m3_wr_data;

    // Scan base+1, base+2, base+3 and optionally base itself; first hit wins.
    // Returns {found, index}. Iterating from the far end lets the nearest
    // requester overwrite earlier hits.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] base,
                                           input logic       incl_base);
        logic [1:0] cand;
        rr_pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            cand = base + 2'(i);
            if (req[cand] && (i != 4 || incl_base)) begin
                rr_pick = {1'b1, cand};
            end
        end
    endfunction

    // From idle the previous owner is lowest priority; while granted the
    // current owner is excluded so the search yields a successor.
    assign w_idle_pick = rr_pick(w_req, r_last, 1'b1);
    assign w_next_pick = rr_pick(w_req, r_owner, 1'b0);

    // Never take the bus away while the owner's strobe is low.
    assign w_preempt = (MAX_HOLD != 0) && (r_hold >= HOLD_LIM) &&
                       w_next_pick[2] && w_as_n[r_owner];

    always_comb begin
        w_st_nxt    = r_st;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_st)
            ST_IDLE: begin
                if (w_idle_pick[2]) begin
                    w_st_nxt    = ST_GRANT;
                    w_owner_nxt = w_idle_pick[1:0];
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (w_req[r_owner]) begin
                    if (w_preempt) begin
                        w_owner_nxt = w_next_pick[1:0];
                        w_last_nxt  = r_owner;
                        w_hold_nxt  = '0;
                    end else if (r_hold != '1) begin
                        w_hold_nxt = r_hold + HOLD_W'(1);
                    end
                end else if (w_next_pick[2]) begin
                    // Hand-over on release with no idle bubble.
                    w_owner_nxt = w_next_pick[1:0];
                    w_last_nxt  = r_owner;
                    w_hold_nxt  = '0;
                end else begin
                    w_st_nxt   = ST_IDLE;
                    w_last_nxt = r_owner;
                    w_hold_nxt = '0;
                end
            end
            default: w_st_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_st       <= ST_IDLE;
            r_owner    <= 2'd0;
            r_last     <= 2'd3;
            r_hold     <= '0;
            r_grnt_n   <= 4'hF;
            r_bus_idle <= 1'b1;
        end else begin
            r_st       <= w_st_nxt;
            r_owner    <= w_owner_nxt;
            r_last     <= w_last_nxt;
            r_hold     <= w_hold_nxt;
            r_grnt_n   <= (w_st_nxt == ST_GRANT) ? ~(4'b0001 << w_owner_nxt) : 4'hF;
            r_bus_idle <= (w_st_nxt == ST_IDLE);
        end
    end

    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = r_grnt_n;
    assign bus_idle = r_bus_idle;

    // Zero-latency datapath: selected by registered state only, so the
    // master's signals pass straight through while it owns the bus.
    always_comb begin
        s_addr    = '0;
        s_as_     = 1'b1;
        s_rw      = 1'b1;
        s_wr_data = '0;
        if (r_st == ST_GRANT) begin
            s_addr    = w_addr[r_owner];
            s_as_     = w_as_n[r_owner];
            s_rw      = w_rw[r_owner];
            s_wr_data = w_data[r_owner];
        end
    end

endmodule

// File: tb/tb_bus_master_arb.sv
// tb/tb_bus_master_arb.sv - table-driven scoreboard bench for bus_master_arb

module tb_bus_master_arb;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset_;
    logic [3:0]        req_n;
    logic [3:0]        as_n;
    logic [3:0]        rw;
    logic [ADDR_W-1:0] addr  [4];
    logic [DATA_W-1:0] wdata [4];

    logic              m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [ADDR_W-1:0] s_addr;
    logic              s_as_;
    logic              s_rw;
    logic [DATA_W-1:0] s_wr_data;
    logic              bus_idle;

    always #5 clk = ~clk;

    bus_master_arb #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .m0_req_    (req_n[0]),
        .m0_addr    (addr[0]),
        .m0_as_     (as_n[0]),
        .m0_rw      (rw[0]),
        .m0_wr_data (wdata[0]),
        .m1_req_    (req_n[1]),
        .m1_addr    (addr[1]),
        .m1_as_     (as_n[1]),
        .m1_rw      (rw[1]),
        .m1_wr_data (wdata[1]),
        .m2_req_    (req_n[2]),
        .m2_addr    (addr[2]),
        .m2_as_     (as_n[2]),
        .m2_rw      (rw[2]),
        .m2_wr_data (wdata[2]),
        .m3_req_    (req_n[3]),
        .m3_addr    (addr[3]),
        .m3_as_     (as_n[3]),
        .m3_rw      (rw[3]),
        .m3_wr_data (wdata[3]),
        .m0_grnt_   (m0_grnt_),
        .m1_grnt_   (m1_grnt_),
        .m2_grnt_   (m2_grnt_),
        .m3_grnt_   (m3_grnt_),
        .s_addr     (s_addr),
        .s_as_      (s_as_),
        .s_rw       (s_rw),
        .s_wr_data  (s_wr_data),
        .bus_idle   (bus_idle)
    );

    typedef struct {
        logic       do_rst;
        logic [3:0] req_n;
        logic [3:0] as_n;
        logic [3:0] exp_grnt;
        logic       exp_idle;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] a,
                       input logic [3:0] g, input logic i);
        vec_t v;
        v.do_rst   = r;
        v.req_n    = q;
        v.as_n     = a;
        v.exp_grnt = g;
        v.exp_idle = i;
        vecs.push_back(v);
    endtask

    // Expected shared-bus values follow from the expected owner and the
    // stimulus the bench itself drives.
    task automatic check_outputs(input string tag, input vec_t e);
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic              eas, erw;
        int                own;
        own = -1;
        for (int n = 0; n < 4; n++) if (!e.exp_grnt[n]) own = n;
        ea = '0; ed = '0; eas = 1'b1; erw = 1'b1;
        if (own >= 0) begin
            ea  = {2'(own), 8'hA5};
            ed  = 32'hD000_0000 | 32'(own);
            eas = e.as_n[own];
            erw = 1'((own & 1));
        end
        chk({tag, ".grnt"}, 64'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 64'(e.exp_grnt));
        chk({tag, ".idle"}, 64'(bus_idle), 64'(e.exp_idle));
        chk({tag, ".s_addr"}, 64'(s_addr), 64'(ea));
        chk({tag, ".s_as_"}, 64'(s_as_), 64'(eas));
        chk({tag, ".s_rw"}, 64'(s_rw), 64'(erw));
        chk({tag, ".s_wr_data"}, 64'(s_wr_data), 64'(ed));
    endtask

    initial begin
        vec_t v;
        vec_t e;

        reset_ = 1'b0;
        req_n  = 4'hF;
        as_n   = 4'hF;
        for (int n = 0; n < 4; n++) begin
            addr[n]  = {2'(n), 8'hA5};
            wdata[n] = 32'hD000_0000 | 32'(n);
            rw[n]    = 1'((n & 1));
        end

        repeat (2) @(posedge clk);
        #1;
        e.do_rst = 1'b0; e.req_n = 4'hF; e.as_n = 4'hF; e.exp_grnt = 4'hF; e.exp_idle = 1'b1;
        check_outputs("reset", e);

        // m2 alone from idle
        add(1, 4'b1111, 4'hF, 4'b1111, 1);
        add(0, 4'b1011, 4'hF, 4'b1011, 0);
        add(0, 4'b1011, 4'hF, 4'b1011, 0);
        add(0, 4'b1111, 4'hF, 4'b1111, 1);
        // all request, each releases after two cycles: 0,1,2,3,0
        add(1, 4'b0000, 4'hF, 4'b1110, 0);
        add(0, 4'b0000, 4'hF, 4'b1110, 0);
        add(0, 4'b0001, 4'hF, 4'b1101, 0);
        add(0, 4'b0001, 4'hF, 4'b1101, 0);
        add(0, 4'b0011, 4'hF, 4'b1011, 0);
        add(0, 4'b0011, 4'hF, 4'b1011, 0);
        add(0, 4'b0111, 4'hF, 4'b0111, 0);
        add(0, 4'b0111, 4'hF, 4'b0111, 0);
        add(0, 4'b1100, 4'hF, 4'b1110, 0);
        add(0, 4'b1111, 4'hF, 4'b1111, 1);
        // m1 releases as m3 and m0 request: m3 then m0
        add(1, 4'b1101, 4'hF, 4'b1101, 0);
        add(0, 4'b1101, 4'hF, 4'b1101, 0);
        add(0, 4'b0110, 4'hF, 4'b0111, 0);
        add(0, 4'b1110, 4'hF, 4'b1110, 0);
        add(0, 4'b1111, 4'hF, 4'b1111, 1);
        // m0 holds with strobe high, m2 waits: preempted once hold reaches 4
        add(1, 4'b1110, 4'hF, 4'b1110, 0);
        for (int k = 0; k < 4; k++) add(0, 4'b1010, 4'hF, 4'b1110, 0);
        add(0, 4'b1010, 4'hF, 4'b1011, 0);
        add(0, 4'b1010, 4'hF, 4'b1011, 0);
        add(0, 4'b1111, 4'hF, 4'b1111, 1);
        // same with m0 strobe low: no preemption until strobe rises
        add(1, 4'b1110, 4'b1110, 4'b1110, 0);
        for (int k = 0; k < 6; k++) add(0, 4'b1010, 4'b1110, 4'b1110, 0);
        add(0, 4'b1010, 4'hF, 4'b1011, 0);
        add(0, 4'b1111, 4'hF, 4'b1111, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            if (v.do_rst) begin
                reset_ = 1'b0;
                req_n  = 4'hF;
                as_n   = 4'hF;
                @(negedge clk);
                reset_ = 1'b1;
            end
            req_n = v.req_n;
            as_n  = v.as_n;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check_outputs($sformatf("v%0d", i), e);
        end

        // Reset while m3 is mid-transfer, then pending m0 wins
        @(negedge clk);
        reset_ = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        req_n  = 4'b0111;
        as_n   = 4'b0111;
        e.do_rst = 1'b0; e.req_n = req_n; e.as_n = as_n; e.exp_grnt = 4'b0111; e.exp_idle = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs("m3_own", exp_q.pop_front());
        @(negedge clk);
        req_n = 4'b0110;
        e.req_n = req_n;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs("m3_hold", exp_q.pop_front());
        @(negedge clk);
        reset_ = 1'b0;
        e.exp_grnt = 4'hF; e.exp_idle = 1'b1;
        exp_q.push_back(e);
        #1;
        check_outputs("async_rst", exp_q.pop_front());
        as_n = 4'hF;
        @(negedge clk);
        reset_ = 1'b1;
        e.as_n = as_n; e.exp_grnt = 4'b1110; e.exp_idle = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_outputs("post_rst", exp_q.pop_front());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
